// File: rtl/conv_pkg.sv
// conv_pkg: scheduler FSM states and layer config word field layout
package conv_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;
  localparam int CFG_STRIDE_OFS = 0;
  localparam int CFG_STRIDE_W = 4;
  localparam int CFG_PAD_OFS = 4;
  localparam int CFG_PAD_W = 4;
  localparam int CFG_W_OFS = 8;
  localparam int CFG_W_W = 12;
  localparam int CFG_H_OFS = 20;
  localparam int CFG_H_W = 12;
  localparam int CFG_N_WRAP_C1_OFS = 32;
  localparam int CFG_N_WRAP_C1_W = 10;
  localparam int CFG_N_WRAP_C2_OFS = 42;
  localparam int CFG_N_WRAP_C2_W = 10;
  localparam int CFG_N_LAST_C1_OFS = 52;
  localparam int CFG_N_LAST_C1_W = 12;
endpackage

// File: rtl/burst_router.sv
// burst_router: round-robin unit pointer and beat counter for one stream kind, gating burst starts on full
module burst_router
  import conv_pkg::*;
#(
  parameter int N = 8,
  parameter int BEATS = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         sel,
  input  logic [N-1:0] full,
  output logic         ready,
  output logic         mid,
  output logic [N-1:0] we
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  assign mid = cnt != '0;
  assign ready = en & (mid | ~full[ptr]);
  assign we = (sel & ready) ? N'(1) << ptr : '0;
  // advance beat count per accepted beat; move to next unit when the burst completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
      cnt <= '0;
    end else if (sel & ready) begin
      cnt <= cnt == CW'(BEATS - 1) ? '0 : cnt + 1'b1;
      if (cnt == CW'(BEATS - 1)) ptr <= ptr == PW'(N - 1) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: rtl/conv_sched.sv
// conv_sched: layer scheduler feeding weight/feature buffers of chained conv units; CONV_SCHED_PERF_EN adds stall_cnt
module conv_sched
  import conv_pkg::*;
#(
  parameter int N_CONV_UNIT = 8,
  parameter int DATA_WIDTH = 64,
  parameter int UNIT_BURSTS_WEI = 32,
  parameter int UNIT_BURSTS_FTM = 1024,
  parameter int DRAIN_CYC = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [63:0]            cfg_in,
  output logic [63:0]            cfg_wr_data,
  output logic [63:0]            cfg_rd_data,
  output logic                   cfg_rd_run,
  input  logic [N_CONV_UNIT-1:0] cfg_rd_done,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_kind,
  input  logic [DATA_WIDTH-1:0]  s_data,
  output logic [N_CONV_UNIT-1:0] wb_we,
  output logic [N_CONV_UNIT-1:0] fb_we,
  output logic [DATA_WIDTH-1:0]  di,
  input  logic [N_CONV_UNIT-1:0] wb_full,
  input  logic [N_CONV_UNIT-1:0] fb_full,
  input  logic [N_CONV_UNIT-1:0] wb_suff,
  input  logic [N_CONV_UNIT-1:0] fb_suff,
`ifdef CONV_SCHED_PERF_EN
  output logic [31:0]            stall_cnt,
`endif
  output logic                   pipe_en,
  output logic                   busy,
  output logic                   done
);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  state_t state;
  logic [DW-1:0] dcnt;
  logic suff, en, kind, w_mid, f_mid, w_rdy, f_rdy;
  assign suff = (&wb_suff) & (&fb_suff);
  assign en = state == FILL || state == RUN;
  assign kind = w_mid ? 1'b0 : f_mid ? 1'b1 : s_kind;
  assign s_ready = kind ? f_rdy : w_rdy;
  assign di = s_data;
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign pipe_en = (state == RUN && suff) || (state == DRAIN && !done);
  burst_router #(.N(N_CONV_UNIT), .BEATS(UNIT_BURSTS_WEI)) u_wei (
    .clk(clk), .rstn(rstn), .en(en), .sel(s_valid & ~kind), .full(wb_full),
    .ready(w_rdy), .mid(w_mid), .we(wb_we)
  );
  burst_router #(.N(N_CONV_UNIT), .BEATS(UNIT_BURSTS_FTM)) u_ftm (
    .clk(clk), .rstn(rstn), .en(en), .sel(s_valid & kind), .full(fb_full),
    .ready(f_rdy), .mid(f_mid), .we(fb_we)
  );
  // layer sequencing: latch config, wait for buffers, run, drain pipeline, pulse done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cfg_wr_data <= '0;
      cfg_rd_data <= '0;
      cfg_rd_run <= 1'b0;
      done <= 1'b0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: if (cfg_valid) begin
          cfg_wr_data <= cfg_in;
          state <= FILL;
        end
        FILL: if (suff) begin
          cfg_rd_data <= cfg_wr_data;
          cfg_rd_run <= 1'b1;
          state <= RUN;
        end
        RUN: if (&cfg_rd_done) begin
          cfg_rd_run <= 1'b0;
          dcnt <= '0;
          state <= DRAIN;
        end
        DRAIN: if (done) begin
          done <= 1'b0;
          state <= IDLE;
        end else begin
          done <= dcnt == DW'(DRAIN_CYC - 1);
          dcnt <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CONV_SCHED_PERF_EN
  // saturating count of RUN cycles where the pipeline is starved
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt <= '0;
    else if (state == IDLE && cfg_valid) stall_cnt <= '0;
    else if (state == RUN && !pipe_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed scenario tests for conv_sched with 4 units, 4-beat weight and 8-beat feature bursts
module tb_conv_sched;
  localparam int N = 4;
  logic clk = 0, rstn = 0, cfg_valid = 0, s_valid = 0, s_kind = 0;
  logic [63:0] cfg_in = '0, s_data = '0;
  logic [N-1:0] cfg_rd_done = '0, wb_full = '0, fb_full = '0, wb_suff = '0, fb_suff = '0;
  logic cfg_ready, cfg_rd_run, s_ready, pipe_en, busy, done;
  logic [63:0] cfg_wr_data, cfg_rd_data, di;
  logic [N-1:0] wb_we, fb_we;
  int total = 0, bad = 0;

  conv_sched #(.N_CONV_UNIT(N), .DATA_WIDTH(64), .UNIT_BURSTS_WEI(4), .UNIT_BURSTS_FTM(8), .DRAIN_CYC(8)) dut (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_in(cfg_in),
    .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data), .cfg_rd_run(cfg_rd_run), .cfg_rd_done(cfg_rd_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_kind(s_kind), .s_data(s_data),
    .wb_we(wb_we), .fb_we(fb_we), .di(di), .wb_full(wb_full), .fb_full(fb_full),
    .wb_suff(wb_suff), .fb_suff(fb_suff), .pipe_en(pipe_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    s_valid = 1;
    #2;
    total++;
    if ({cfg_ready, busy, s_ready, pipe_en, done, cfg_rd_run} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=100000", {cfg_ready, busy, s_ready, pipe_en, done, cfg_rd_run});
    end
    total++;
    if ({cfg_wr_data, cfg_rd_data, wb_we, fb_we} !== '0) begin
      bad++;
      $display("FAIL reset_data wr=%h rd=%h wb_we=%b fb_we=%b want all 0", cfg_wr_data, cfg_rd_data, wb_we, fb_we);
    end
    s_valid = 0;
    step();
    step();
    rstn = 1;
  endtask

  task automatic test_cfg(input logic [63:0] c);
    cfg_in = c;
    cfg_valid = 1;
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_ready_idle got=%b want=1", cfg_ready);
    end
    step();
    cfg_valid = 0;
    #1;
    total++;
    if ({busy, cfg_ready, cfg_rd_run, cfg_wr_data} !== {3'b100, c}) begin
      bad++;
      $display("FAIL cfg_fill busy=%b ready=%b run=%b wr=%h want 1,0,0,%h", busy, cfg_ready, cfg_rd_run, cfg_wr_data, c);
    end
  endtask

  task automatic test_weight_bursts();
    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] exp;
      exp = N'(1 << ((i / 4) % 4));
      s_valid = 1;
      s_kind = (i % 4 != 0) && (i % 2 == 1);
      s_data = 64'hA000 + 64'(i);
      #1;
      total++;
      if ({s_ready, wb_we, fb_we, di} !== {1'b1, exp, 4'b0000, 64'hA000 + 64'(i)}) begin
        bad++;
        $display("FAIL wei_beat%0d rdy=%b wb_we=%b fb_we=%b di=%h want 1,%b,0000,%h", i, s_ready, wb_we, fb_we, di, exp, 64'hA000 + 64'(i));
      end
      step();
    end
    s_valid = 0;
    s_kind = 0;
  endtask

  task automatic test_feature_full();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1;
      s_kind = 1;
      #1;
      total++;
      if ({s_ready, fb_we, wb_we} !== {1'b1, 4'b0001, 4'b0000}) begin
        bad++;
        $display("FAIL ftm0_beat%0d rdy=%b fb_we=%b wb_we=%b want 1,0001,0000", i, s_ready, fb_we, wb_we);
      end
      step();
    end
    fb_full = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({s_ready, fb_we} !== 5'b0_0000) begin
        bad++;
        $display("FAIL ftm1_stall%0d rdy=%b fb_we=%b want 0,0000", i, s_ready, fb_we);
      end
      step();
    end
    for (int i = 0; i < 8; i++) begin
      fb_full = (i >= 3) ? 4'b0010 : 4'b0000;
      #1;
      total++;
      if ({s_ready, fb_we} !== 5'b1_0010) begin
        bad++;
        $display("FAIL ftm1_beat%0d rdy=%b fb_we=%b want 1,0010", i, s_ready, fb_we);
      end
      step();
    end
    s_valid = 0;
    s_kind = 0;
    fb_full = 0;
  endtask

  task automatic test_run();
    wb_suff = 4'hF;
    fb_suff = 4'hF;
    #1;
    total++;
    if ({cfg_rd_run, pipe_en} !== 2'b00) begin
      bad++;
      $display("FAIL fill_no_run run=%b pipe_en=%b want 0,0", cfg_rd_run, pipe_en);
    end
    step();
    total++;
    if ({cfg_rd_run, pipe_en, cfg_rd_data} !== {2'b11, 64'h1234}) begin
      bad++;
      $display("FAIL run_start run=%b pipe_en=%b rd=%h want 1,1,1234", cfg_rd_run, pipe_en, cfg_rd_data);
    end
    wb_suff = 4'b1011;
    #1;
    total++;
    if (pipe_en !== 1'b0) begin
      bad++;
      $display("FAIL run_starve pipe_en=%b want 0", pipe_en);
    end
    wb_suff = 4'hF;
    #1;
    total++;
    if (pipe_en !== 1'b1) begin
      bad++;
      $display("FAIL run_resume pipe_en=%b want 1", pipe_en);
    end
  endtask

  task automatic test_done_with_beat();
    s_valid = 1;
    s_kind = 0;
    cfg_rd_done = 4'hF;
    #1;
    total++;
    if ({s_ready, wb_we} !== 5'b1_0010) begin
      bad++;
      $display("FAIL done_beat rdy=%b wb_we=%b want 1,0010", s_ready, wb_we);
    end
    step();
    s_valid = 0;
    cfg_rd_done = 0;
    #1;
    total++;
    if ({cfg_rd_run, busy, cfg_ready} !== 3'b010) begin
      bad++;
      $display("FAIL drain_enter run=%b busy=%b ready=%b want 0,1,0", cfg_rd_run, busy, cfg_ready);
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({pipe_en, done} !== 2'b10) begin
        bad++;
        $display("FAIL drain_cyc%0d pipe_en=%b done=%b want 1,0", k, pipe_en, done);
      end
      step();
    end
    total++;
    if ({pipe_en, done, cfg_ready} !== 3'b010) begin
      bad++;
      $display("FAIL done_pulse pipe_en=%b done=%b ready=%b want 0,1,0", pipe_en, done, cfg_ready);
    end
    step();
    total++;
    if ({done, cfg_ready, busy, pipe_en} !== 4'b0100) begin
      bad++;
      $display("FAIL back_idle done=%b ready=%b busy=%b pipe_en=%b want 0,1,0,0", done, cfg_ready, busy, pipe_en);
    end
    wb_suff = 0;
    fb_suff = 0;
  endtask

  task automatic test_reset_mid_burst();
    test_cfg(64'h55AA);
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] exp;
      exp = (i < 3) ? 4'b0010 : 4'b0100;
      s_valid = 1;
      s_kind = 0;
      #1;
      if (i == 5) begin
        rstn = 0;
        #1;
        total++;
        if ({s_ready, wb_we, busy, cfg_rd_run, cfg_wr_data} !== '0) begin
          bad++;
          $display("FAIL async_reset rdy=%b wb_we=%b busy=%b run=%b wr=%h want all 0", s_ready, wb_we, busy, cfg_rd_run, cfg_wr_data);
        end
      end else begin
        total++;
        if ({s_ready, wb_we} !== {1'b1, exp}) begin
          bad++;
          $display("FAIL pre_reset_beat%0d rdy=%b wb_we=%b want 1,%b", i, s_ready, wb_we, exp);
        end
      end
      step();
    end
    s_valid = 0;
    step();
    rstn = 1;
    test_cfg(64'h77);
    for (int i = 0; i < 5; i++) begin
      logic [N-1:0] exp;
      exp = (i < 4) ? 4'b0001 : 4'b0010;
      s_valid = 1;
      #1;
      total++;
      if ({s_ready, wb_we} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL post_reset_beat%0d rdy=%b wb_we=%b want 1,%b", i, s_ready, wb_we, exp);
      end
      step();
    end
    s_valid = 0;
  endtask

  initial begin
    test_reset();
    test_cfg(64'h1234);
    test_weight_bursts();
    test_feature_full();
    test_run();
    test_done_with_beat();
    test_drain();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
